// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXE/MEM/WB sequencer driving a multi-cycle MIPS-subset datapath.
// Define MCTRL_PERF_EN to add the cycle_cnt / instr_cnt performance counters.
module multicycle_ctrl #(
    parameter int PERF_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       npc_sel,
    output logic       j_ctl,
    output logic [1:0] alu_ctl,
    output logic       alu_src,
    output logic [1:0] ext_op,
    output logic       reg_dst,
    output logic [1:0] reg_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_read,
    output logic       illegal,
    output logic [2:0] state_o
`ifdef MCTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instr_cnt
`endif
);

    // Memory handshake: imem_ready/dmem_ready are sampled every cycle in FETCH/MEM.
    // A cycle with ready=1 completes the access and advances; while ready=0 the
    // state and all request strobes are held unchanged.

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BR     = 3'd5,
        S_JMP    = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    state_t     state;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic       illegal_q;

    logic live_beq;
    logic live_j;
    logic live_exe;

    logic is_addu;
    logic is_subu;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;

    // Decode of the freshly loaded IR, used only to pick the DECODE successor.
    always_comb begin
        live_beq = (opcode == OP_BEQ);
        live_j   = (opcode == OP_J);
        live_exe = ((opcode == OP_RTYPE) && ((funct == FN_ADDU) || (funct == FN_SUBU)))
                 || (opcode == OP_ORI) || (opcode == OP_LUI)
                 || (opcode == OP_LW)  || (opcode == OP_SW);
    end

    always_comb begin
        is_addu = (op_q == OP_RTYPE) && (fn_q == FN_ADDU);
        is_subu = (op_q == OP_RTYPE) && (fn_q == FN_SUBU);
        is_ori  = (op_q == OP_ORI);
        is_lui  = (op_q == OP_LUI);
        is_lw   = (op_q == OP_LW);
        is_sw   = (op_q == OP_SW);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            op_q      <= '0;
            fn_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= opcode;
                    fn_q <= funct;
                    if (live_beq) begin
                        state <= S_BR;
                    end else if (live_j) begin
                        state <= S_JMP;
                    end else if (live_exe) begin
                        state <= S_EXE;
                    end else begin
                        illegal_q <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_EXE: begin
                    state <= (is_lw || is_sw) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) state <= is_lw ? S_WB : S_FETCH;
                end
                S_WB:    state <= S_FETCH;
                S_BR:    state <= S_FETCH;
                S_JMP:   state <= S_FETCH;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Outputs are decoded straight from state and the latched instruction and
    // are all held low while rst is asserted, so an abandoned access drops at once.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        npc_sel   = 1'b0;
        j_ctl     = 1'b0;
        alu_ctl   = 2'b00;
        alu_src   = 1'b0;
        ext_op    = 2'b00;
        reg_dst   = 1'b0;
        reg_src   = 2'b00;
        reg_write = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    ir_write = imem_ready;
                    pc_write = imem_ready;
                end
                // ALU controls stay up through MEM and WB so the address and
                // result remain stable without an ALU output register.
                S_EXE, S_MEM, S_WB: begin
                    if (is_subu) alu_ctl = 2'b01;
                    if (is_ori) begin
                        alu_src = 1'b1;
                        ext_op  = 2'b00;
                        alu_ctl = 2'b10;
                    end
                    if (is_lui) ext_op = 2'b10;
                    if (is_lw || is_sw) begin
                        alu_src = 1'b1;
                        ext_op  = 2'b01;
                    end
                    if (state == S_MEM) begin
                        mem_read  = is_lw;
                        mem_write = is_sw;
                    end
                    if (state == S_WB) begin
                        reg_write = 1'b1;
                        reg_dst   = is_addu || is_subu;
                        reg_src   = is_lui ? 2'b10 : (is_lw ? 2'b01 : 2'b00);
                    end
                end
                S_BR: begin
                    alu_ctl  = 2'b01;
                    npc_sel  = 1'b1;
                    pc_write = zero;
                end
                S_JMP: begin
                    j_ctl    = 1'b1;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign illegal = rst & illegal_q;
    assign state_o = rst ? state : S_FETCH;

`ifdef MCTRL_PERF_EN
    logic instr_done;

    // An instruction retires on every return to FETCH except the illegal skip.
    assign instr_done = (state == S_WB) || (state == S_BR) || (state == S_JMP)
                      || ((state == S_MEM) && dmem_ready && is_sw);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + PERF_W'(1);
            if (instr_done) instr_cnt <= instr_cnt + PERF_W'(1);
        end
    end
`else
    // Keeps PERF_W referenced when the counters are compiled out.
    if (PERF_W < 1) begin : g_perf_w_unused
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control vectors are queued
// when an instruction is generated and compared while the DUT steps through it.
module tb_multicycle_ctrl;

    localparam int PERF_W = 32;
    localparam int W      = 19;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_write;
        logic       ir_write;
        logic       npc_sel;
        logic       j_ctl;
        logic [1:0] alu_ctl;
        logic       alu_src;
        logic [1:0] ext_op;
        logic       reg_dst;
        logic [1:0] reg_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       im;
        logic       dm;
    } stim_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       pc_write, ir_write, npc_sel, j_ctl, alu_src, reg_dst;
    logic       reg_write, mem_write, mem_read, illegal;
    logic [1:0] alu_ctl, ext_op, reg_src;
    logic [2:0] state_o;
    logic [PERF_W-1:0] cycle_cnt;
    logic [PERF_W-1:0] instr_cnt;

    multicycle_ctrl #(.PERF_W(PERF_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .npc_sel    (npc_sel),
        .j_ctl      (j_ctl),
        .alu_ctl    (alu_ctl),
        .alu_src    (alu_src),
        .ext_op     (ext_op),
        .reg_dst    (reg_dst),
        .reg_src    (reg_src),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .illegal    (illegal),
        .state_o    (state_o)
`ifdef MCTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

`ifndef MCTRL_PERF_EN
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

    logic [W-1:0] act;
    assign act = {state_o, pc_write, ir_write, npc_sel, j_ctl, alu_ctl, alu_src,
                  ext_op, reg_dst, reg_src, reg_write, mem_write, mem_read, illegal};

    // scoreboard state
    logic [W-1:0] exp_q[$];
    stim_t        stim_q[$];
    int           n_checks = 0;
    int           n_errs   = 0;
    int           cyc      = 0;
    logic         exp_illegal = 1'b0;
    int           exp_instr   = 0;
    int           exp_cycles  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) exp_cycles <= 0;
        else      exp_cycles <= exp_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic ctl_t base(input logic [2:0] st);
        ctl_t c;
        c         = '0;
        c.state   = st;
        c.illegal = exp_illegal;
        return c;
    endfunction

    task automatic push(input ctl_t c, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic im, input logic dm);
        stim_t s;
        s.op = op;
        s.fn = fn;
        s.z  = z;
        s.im = im;
        s.dm = dm;
        exp_q.push_back(c);
        stim_q.push_back(s);
    endtask

    // driver: apply one stimulus per cycle and compare against the queued expectation
    task automatic run_q();
        stim_t        s;
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            opcode     = s.op;
            funct      = s.fn;
            zero       = s.z;
            imem_ready = s.im;
            dmem_ready = s.dm;
            #1;
            e = exp_q.pop_front();
            check($sformatf("cyc%0d_st%0d", cyc, e[W-1 -: 3]), act, e);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic check_perf();
`ifdef MCTRL_PERF_EN
        check("instr_cnt", instr_cnt, exp_instr);
        check("cycle_cnt", cycle_cnt, exp_cycles);
`endif
    endtask

    // reference model: expected control vector for every cycle of one instruction
    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int i_stall, input int d_stall, input bit abort_mem);
        ctl_t c;
        ctl_t ex;
        bit r_add, r_sub, i_ori, i_lui, i_lw, i_sw, i_beq, i_j;
        r_add = (op == 6'b000000) && (fn == 6'b100001);
        r_sub = (op == 6'b000000) && (fn == 6'b100011);
        i_ori = (op == 6'b001101);
        i_lui = (op == 6'b001111);
        i_lw  = (op == 6'b100011);
        i_sw  = (op == 6'b101011);
        i_beq = (op == 6'b000100);
        i_j   = (op == 6'b000010);
        for (int k = 0; k < i_stall; k++) push(base(3'd0), op, fn, z, 1'b0, rnd());
        c = base(3'd0);
        c.pc_write = 1'b1;
        c.ir_write = 1'b1;
        push(c, op, fn, z, 1'b1, rnd());
        push(base(3'd1), op, fn, z, rnd(), rnd());
        if (i_beq) begin
            c = base(3'd5);
            c.alu_ctl  = 2'b01;
            c.npc_sel  = 1'b1;
            c.pc_write = z;
            push(c, op, fn, z, rnd(), rnd());
            exp_instr++;
        end else if (i_j) begin
            c = base(3'd6);
            c.j_ctl    = 1'b1;
            c.pc_write = 1'b1;
            push(c, op, fn, z, rnd(), rnd());
            exp_instr++;
        end else if (r_add || r_sub || i_ori || i_lui || i_lw || i_sw) begin
            ex = base(3'd2);
            if (r_sub) ex.alu_ctl = 2'b01;
            if (i_ori) begin
                ex.alu_src = 1'b1;
                ex.alu_ctl = 2'b10;
            end
            if (i_lui) ex.ext_op = 2'b10;
            if (i_lw || i_sw) begin
                ex.alu_src = 1'b1;
                ex.ext_op  = 2'b01;
            end
            push(ex, op, fn, z, rnd(), rnd());
            if (i_lw || i_sw) begin
                c = ex;
                c.state     = 3'd3;
                c.mem_read  = i_lw;
                c.mem_write = i_sw;
                for (int k = 0; k < d_stall; k++) push(c, op, fn, z, rnd(), 1'b0);
                if (!abort_mem) push(c, op, fn, z, rnd(), 1'b1);
            end
            if (!abort_mem) begin
                if (!i_sw) begin
                    c = ex;
                    c.state     = 3'd4;
                    c.reg_write = 1'b1;
                    c.reg_dst   = r_add || r_sub;
                    c.reg_src   = i_lui ? 2'b10 : (i_lw ? 2'b01 : 2'b00);
                    push(c, op, fn, z, rnd(), rnd());
                end
                exp_instr++;
            end
        end else begin
            exp_illegal = 1'b1;
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int i_stall, input int d_stall);
        gen_instr(op, fn, z, i_stall, d_stall, 1'b0);
        run_q();
        check_perf();
    endtask

    logic [5:0] op_tab [8] = '{6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02};
    logic [5:0] fn_tab [8] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        opcode     = '0;
        funct      = '0;
        zero       = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        @(negedge clk);

        // reset held three cycles with imem_ready high: everything low
        for (int k = 0; k < 3; k++) push(base(3'd0), 6'h00, 6'h00, 1'b0, 1'b1, 1'b1);
        run_q();
        check_perf();
        rst = 1'b1;

        // directed instructions with readies high
        do_instr(6'b000000, 6'b100001, 1'b0, 0, 0);  // addu
        do_instr(6'b000000, 6'b100011, 1'b0, 0, 0);  // subu
        do_instr(6'b001101, 6'b010101, 1'b0, 0, 0);  // ori
        do_instr(6'b001111, 6'b000000, 1'b0, 0, 0);  // lui
        do_instr(6'b101011, 6'b000000, 1'b0, 0, 0);  // sw
        do_instr(6'b000010, 6'b000000, 1'b0, 0, 0);  // j
        do_instr(6'b100011, 6'b000000, 1'b0, 0, 3);  // lw, dmem stalled 3 cycles
        do_instr(6'b000100, 6'b000000, 1'b1, 0, 0);  // beq taken
        do_instr(6'b000100, 6'b000000, 1'b0, 0, 0);  // beq not taken
        do_instr(6'b100011, 6'b000000, 1'b0, 2, 0);  // lw, imem stalled

        // random legal mix with random stalls
        for (int n = 0; n < 24; n++) begin
            int idx;
            idx = $urandom_range(0, 7);
            do_instr(op_tab[idx], (idx < 2) ? fn_tab[idx] : 6'($urandom_range(0, 63)),
                     rnd(), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // illegal opcode, then sticky flag across further instructions
        do_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        do_instr(6'b000000, 6'b100001, 1'b0, 0, 0);
        do_instr(6'b000000, 6'b100000, 1'b0, 0, 0);  // unsupported funct
        do_instr(6'b100011, 6'b000000, 1'b0, 1, 1);

        // reset in the middle of a stalled sw
        gen_instr(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b1);
        run_q();
        dmem_ready = 1'b0;
        #1;
        check("sw_mem_write_before_rst", mem_write, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_mid_mem_outputs", act, '0);
`ifdef MCTRL_PERF_EN
        check("rst_mid_mem_instr_cnt", instr_cnt, 0);
        check("rst_mid_mem_cycle_cnt", cycle_cnt, 0);
`endif
        exp_illegal = 1'b0;
        exp_instr   = 0;
        @(negedge clk);
        rst = 1'b1;
        do_instr(6'b000000, 6'b100001, 1'b0, 0, 0);
        do_instr(6'b101011, 6'b000000, 1'b0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
